// File: rtl/uart_host_sched.sv
// uart_host_sched: sole master of the UART 4x8-bit register bus; runs init, polls status, arbitrates two TX requesters, delivers RX bytes and errors.
// Build option: define UART_HOST_SCHED_RR_EN for round-robin TX arbitration (fixed priority to req0 otherwise).
module uart_host_sched #(
    parameter logic [15:0] BR_DIV    = 16'd325,
    parameter logic [7:0]  CTRL_INIT = 8'h1C
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       cfg_reload,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic       busy_init,
    output logic [1:0] adr,
    inout  wire  [7:0] dat,
    output logic       we,
    output logic       ce
);

    localparam logic [2:0] ST_INIT_BRL = 3'd0;
    localparam logic [2:0] ST_INIT_BRM = 3'd1;
    localparam logic [2:0] ST_INIT_CTL = 3'd2;
    localparam logic [2:0] ST_POLL     = 3'd3;
    localparam logic [2:0] ST_WR_TX    = 3'd4;
    localparam logic [2:0] ST_RD_RX    = 3'd5;

    logic [2:0] state_r;
    logic [2:0] next_s;
    logic       start_r;
    logic       reload_r;
    logic       reload_s;
    logic       grant_s;
    logic       init_s;
    logic       ce_r;
    logic       we_r;
    logic [1:0] adr_r;
    logic [7:0] dat_r;
    logic       req0_ready_r;
    logic       req1_ready_r;
    logic       rx_valid_r;
    logic [7:0] rx_data_r;
    logic       err_valid_r;
    logic [2:0] err_code_r;
    logic       busy_r;
`ifdef UART_HOST_SCHED_RR_EN
    logic       last_r;
`endif

    // Next-state selection; start_r holds INIT_BRL for the idle cycle right after reset release
    always_comb begin
        reload_s = reload_r | cfg_reload;
        next_s   = ST_POLL;
        if (!start_r) begin
            next_s = ST_INIT_BRL;
        end else if (reload_s) begin
            next_s = ST_INIT_BRL;
        end else begin
            case (state_r)
                ST_INIT_BRL: next_s = ST_INIT_BRM;
                ST_INIT_BRM: next_s = ST_INIT_CTL;
                ST_INIT_CTL: next_s = ST_POLL;
                ST_POLL: begin
                    if (dat[0]) begin
                        next_s = ST_RD_RX;
                    end else if (dat[5] && (req0_valid || req1_valid)) begin
                        next_s = ST_WR_TX;
                    end else begin
                        next_s = ST_POLL;
                    end
                end
                ST_WR_TX:    next_s = ST_POLL;
                ST_RD_RX:    next_s = ST_POLL;
                default:     next_s = ST_INIT_BRL;
            endcase
        end
    end

    assign init_s = (next_s == ST_INIT_BRL) || (next_s == ST_INIT_BRM) || (next_s == ST_INIT_CTL);

    // TX arbitration: grant_s = 1 selects req1
    always_comb begin
`ifdef UART_HOST_SCHED_RR_EN
        if (req0_valid && req1_valid) begin
            grant_s = ~last_r;
        end else begin
            grant_s = ~req0_valid;
        end
`else
        grant_s = ~req0_valid;
`endif
    end

    // FSM state and reload latch
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r  <= ST_INIT_BRL;
            start_r  <= 1'b0;
            reload_r <= 1'b0;
        end else begin
            state_r  <= next_s;
            start_r  <= 1'b1;
            reload_r <= reload_s && (next_s != ST_INIT_BRL);
        end
    end

    // Bus and ready registers are loaded with the values of the state being entered
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ce_r         <= 1'b0;
            we_r         <= 1'b0;
            adr_r        <= 2'd0;
            dat_r        <= 8'h00;
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
        end else begin
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            case (next_s)
                ST_INIT_BRL: begin ce_r <= 1'b1; we_r <= 1'b1; adr_r <= 2'd2; dat_r <= BR_DIV[7:0];  end
                ST_INIT_BRM: begin ce_r <= 1'b1; we_r <= 1'b1; adr_r <= 2'd3; dat_r <= BR_DIV[15:8]; end
                ST_INIT_CTL: begin ce_r <= 1'b1; we_r <= 1'b1; adr_r <= 2'd1; dat_r <= CTRL_INIT;    end
                ST_POLL:     begin ce_r <= 1'b1; we_r <= 1'b0; adr_r <= 2'd1; dat_r <= 8'h00;        end
                ST_WR_TX: begin
                    ce_r         <= 1'b1;
                    we_r         <= 1'b1;
                    adr_r        <= 2'd0;
                    dat_r        <= grant_s ? req1_data : req0_data;
                    req0_ready_r <= ~grant_s;
                    req1_ready_r <= grant_s;
                end
                ST_RD_RX:    begin ce_r <= 1'b1; we_r <= 1'b0; adr_r <= 2'd0; dat_r <= 8'h00;        end
                default:     begin ce_r <= 1'b0; we_r <= 1'b0; adr_r <= 2'd0; dat_r <= 8'h00;        end
            endcase
        end
    end

    // Host-side delivery: RX byte after RD_RX, error flags sampled in POLL
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_valid_r  <= 1'b0;
            rx_data_r   <= 8'h00;
            err_valid_r <= 1'b0;
            err_code_r  <= 3'd0;
            busy_r      <= 1'b1;
        end else begin
            rx_valid_r  <= (state_r == ST_RD_RX);
            rx_data_r   <= (state_r == ST_RD_RX) ? dat : rx_data_r;
            err_valid_r <= (state_r == ST_POLL) && (dat[3:1] != 3'd0);
            err_code_r  <= ((state_r == ST_POLL) && (dat[3:1] != 3'd0)) ? dat[3:1] : err_code_r;
            busy_r      <= init_s;
        end
    end

`ifdef UART_HOST_SCHED_RR_EN
    // Round-robin pointer remembers the requester served by the last completed WR_TX
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_r <= 1'b1;
        end else if (state_r == ST_WR_TX) begin
            last_r <= req1_ready_r;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    assign ce         = ce_r;
    assign we         = we_r;
    assign adr        = adr_r;
    assign dat        = we_r ? dat_r : 8'hzz;
    assign req0_ready = req0_ready_r;
    assign req1_ready = req1_ready_r;
    assign rx_valid   = rx_valid_r;
    assign rx_data    = rx_data_r;
    assign err_valid  = err_valid_r;
    assign err_code   = err_code_r;
    assign busy_init  = busy_r;

endmodule
